// File: rtl/fir_stream_pkg.sv
// fir_stream_pkg: shared state encoding and default widths for the FIR stream driver
package fir_stream_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  localparam int IN_W_DEF = 16;
  localparam int OUT_W_DEF = 38;
  localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: power-of-two synchronous FIFO; pushes while full and pops while empty are dropped
module sample_fifo
  import fir_stream_pkg::*;
#(
  parameter int W = IN_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [CW-1:0] count;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem[rd];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= data;
endmodule

// File: rtl/fir_stream_driver.sv
// fir_stream_driver: buffers samples, issues them one at a time to the FIR core and registers each result
module fir_stream_driver
  import fir_stream_pkg::*;
#(
  parameter int IN_W = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  output logic             fir_inputValid,
  output logic [IN_W-1:0]  fir_input,
  input  logic             fir_outputValid,
  input  logic [OUT_W-1:0] fir_output,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             timeout_err,
  output logic [31:0]      issue_count
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, next;
  logic [IN_W-1:0] head;
  logic [TW-1:0] wcnt;
  logic full, empty, go, capture, expire;
  sample_fifo #(.W(IN_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(s_valid), .pop(go), .data(s_data),
    .head(head), .full(full), .empty(empty)
  );
  assign s_ready = !full;
  // issue only when the result register is free or draining this cycle
  assign go = state == IDLE && !empty && (!m_valid || m_ready);
  assign capture = state == WAIT && fir_outputValid;
  assign expire = state == WAIT && !fir_outputValid && wcnt == TW'(TIMEOUT - 1);
  always_comb begin
    next = state;
    fir_inputValid = state == ISSUE;
    if (go) next = ISSUE;
    else if (state == ISSUE) next = WAIT;
    else if (capture || expire) next = IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      fir_input <= '0;
      m_valid <= 1'b0;
      m_data <= '0;
      timeout_err <= 1'b0;
      issue_count <= '0;
      wcnt <= '0;
    end else begin
      state <= next;
      if (go) begin
        fir_input <= head;
        issue_count <= issue_count + 32'd1;
      end
      wcnt <= state == ISSUE ? '0 : state == WAIT ? wcnt + 1'b1 : wcnt;
      if (expire) timeout_err <= 1'b1;
      if (capture) m_data <= fir_output;
      m_valid <= capture || (m_valid && !m_ready);
    end
endmodule

// File: tb/tb_fir_stream_driver.sv
// tb_fir_stream_driver: directed checks of the FIR stream driver against a squaring FIR model
module tb_fir_stream_driver;
  localparam int LAT = 3;
  logic clk = 0, rst = 0;
  logic s_valid = 0, s_ready, fir_inputValid, fir_outputValid, m_valid, m_ready = 1, timeout_err;
  logic [15:0] s_data = '0, fir_input;
  logic [37:0] fir_output, m_data;
  logic [31:0] issue_count;
  logic model_en = 0, fov_m = 0, fov_man = 0;
  logic [37:0] held = '0, man_data = '0;
  int mcnt = 0;
  int checks = 0, failures = 0;
  logic [15:0] iss_q[$];
  logic [37:0] res_q[$];

  always #5 clk = ~clk;

  fir_stream_driver #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .fir_inputValid(fir_inputValid), .fir_input(fir_input),
    .fir_outputValid(fir_outputValid), .fir_output(fir_output),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .timeout_err(timeout_err), .issue_count(issue_count)
  );

  // FIR model: answers sample*sample LAT cycles after the strobe
  assign fir_outputValid = fov_m || fov_man;
  assign fir_output = fov_m ? held * held : man_data;
  always @(negedge clk)
    if (!rst) begin
      mcnt = 0;
      fov_m = 0;
    end else begin
      fov_m = 0;
      if (mcnt != 0) begin
        mcnt--;
        if (mcnt == 0) fov_m = 1;
      end
      if (fir_inputValid && model_en) begin
        mcnt = LAT;
        held = {22'b0, fir_input};
      end
    end

  always @(negedge clk) begin
    if (rst && fir_inputValid) iss_q.push_back(fir_input);
    if (rst && m_valid && m_ready) res_q.push_back(m_data);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    int n = 0;
    s_valid = 1;
    s_data = v;
    while (!s_ready && n < 50) begin
      tick;
      n++;
    end
    chk("push_ready", s_ready, 1);
    tick;
    s_valid = 0;
  endtask

  task automatic wait_mvalid(input string tag);
    int n = 0;
    while (!m_valid && n < 40) begin
      tick;
      n++;
    end
    chk(tag, m_valid, 1);
  endtask

  initial begin
    repeat (2) tick;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_strobe", fir_inputValid, 0);
    chk("rst_fir_input", fir_input, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_issue_count", issue_count, 0);
    rst = 1;
    tick;
    // single sample
    model_en = 1;
    s_valid = 1;
    s_data = 16'h0005;
    tick;
    s_valid = 0;
    chk("single_no_early_strobe", fir_inputValid, 0);
    tick;
    chk("single_strobe", fir_inputValid, 1);
    chk("single_fir_input", fir_input, 16'h0005);
    chk("single_issue_count", issue_count, 1);
    tick;
    chk("single_strobe_one_cycle", fir_inputValid, 0);
    repeat (2) tick;
    chk("single_m_valid_early", m_valid, 0);
    tick;
    chk("single_m_valid", m_valid, 1);
    chk("single_m_data", m_data, 38'h19);
    tick;
    chk("single_m_drained", m_valid, 0);
    // spurious response while idle
    fov_man = 1;
    man_data = 38'h3FF;
    tick;
    fov_man = 0;
    chk("spurious_m_valid", m_valid, 0);
    chk("spurious_m_data", m_data, 38'h19);
    // backpressure: FIR silent until the first response is forced by hand
    model_en = 0;
    iss_q.delete();
    res_q.delete();
    for (int i = 1; i <= 4; i++) push(16'(i));
    chk("bp_ready_after4", s_ready, 1);
    push(16'd5);
    chk("bp_full", s_ready, 0);
    s_valid = 1;
    s_data = 16'd6;
    tick;
    chk("bp_still_full", s_ready, 0);
    fov_man = 1;
    man_data = 38'd1;
    model_en = 1;
    tick;
    fov_man = 0;
    chk("bp_first_result", m_data, 1);
    push(16'd6);
    for (int n = 0; n < 200 && res_q.size() < 6; n++) tick;
    chk("bp_result_count", res_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk("bp_issue_order", iss_q[i], 16'(i + 1));
      chk("bp_result_value", res_q[i], 38'((i + 1) * (i + 1)));
    end
    // downstream stall
    m_ready = 0;
    iss_q.delete();
    push(16'd7);
    push(16'd8);
    wait_mvalid("stall_first_valid");
    chk("stall_first_data", m_data, 38'd49);
    repeat (5) tick;
    chk("stall_no_second_issue", iss_q.size(), 1);
    chk("stall_no_strobe", fir_inputValid, 0);
    m_ready = 1;
    tick;
    m_ready = 0;
    chk("stall_release_strobe", fir_inputValid, 1);
    chk("stall_release_input", fir_input, 16'd8);
    chk("stall_release_drained", m_valid, 0);
    wait_mvalid("stall_second_valid");
    chk("stall_second_data", m_data, 38'd64);
    m_ready = 1;
    tick;
    // timeout with TIMEOUT=8
    model_en = 0;
    push(16'd9);
    push(16'd10);
    chk("to_strobe", fir_inputValid, 1);
    chk("to_input", fir_input, 16'd9);
    tick;
    repeat (7) tick;
    chk("to_not_yet", timeout_err, 0);
    tick;
    chk("to_set", timeout_err, 1);
    chk("to_no_result", m_valid, 0);
    model_en = 1;
    tick;
    chk("to_next_strobe", fir_inputValid, 1);
    chk("to_next_input", fir_input, 16'd10);
    wait_mvalid("to_next_valid");
    chk("to_next_data", m_data, 38'd100);
    chk("to_sticky", timeout_err, 1);
    chk("issue_count_total", issue_count, 11);
    tick;
    // reset during WAIT
    model_en = 0;
    push(16'd11);
    tick;
    tick;
    #2 rst = 0;
    #1;
    chk("mid_rst_s_ready", s_ready, 1);
    chk("mid_rst_strobe", fir_inputValid, 0);
    chk("mid_rst_fir_input", fir_input, 0);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_m_data", m_data, 0);
    chk("mid_rst_timeout", timeout_err, 0);
    chk("mid_rst_issue_count", issue_count, 0);
    tick;
    rst = 1;
    fov_man = 1;
    man_data = 38'd5;
    tick;
    fov_man = 0;
    tick;
    chk("late_result_ignored", m_valid, 0);
    chk("late_result_data", m_data, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
